player_health: RTL and testbench
================================

# player_health

Parametrised player life tracker and health HUD for the arena: successor to the fixed five-life counter. Counts lives from any number of hazard sources. Enforces post-hit invulnerability with sprite blinking, and accepts extra-life pickups and a restart request. Drives the game-over flag, the HUD health bar and the life-shaded background consumed by the pixel mux.

## Interface
Parameters:
- MAX_LIVES, 5: life cap; LIFE_W = $clog2(MAX_LIVES+1)
- START_LIVES, 5: lives after reset/restart; must be 1..MAX_LIVES
- N_HAZARDS, 2: number of hazard overlap inputs (enemy, explosion, ...)
- INVULN_CYCLES, 150000000: invulnerability length in clocks
- BLINK_CYCLES, 6250000: sprite-visibility half-period during invulnerability
- BAR_X0, 576 / BAR_Y0, 5 / BAR_H, 8 / SEG_W, 4: health-bar origin, height, pixels per life

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- x, y  in  10 each  current pixel
- bm_hb_on  in  1  pixel is inside bomberman hitbox
- hazard_on  in  N_HAZARDS  pixel is inside hazard k
- life_up  in  1  one-cycle pickup pulse
- restart  in  1  one-cycle restart request
- lives  out  LIFE_W  current life count
- invuln  out  1  invulnerability active
- bm_visible  out  1  sprite draw enable (blink)
- hit_pulse  out  1  one-cycle pulse per accepted hit
- gameover  out  1  lives exhausted
- healthbar_on  out  1  pixel inside health bar
- healthbar_rgb  out  12  bar colour
- background_rgb  out  12  frame colour

## Operation
- hit = bm_hb_on & |hazard_on, combinational.
- FSM states: ALIVE, INVULN, DEAD.
- ALIVE + hit:
  - lives -= 1 and hit_pulse asserted.
  - Go to DEAD if lives reaches 0, else go to INVULN with the timer cleared.
- ALIVE/INVULN + life_up: lives += 1, saturating at MAX_LIVES.
- Hit and life_up in the same ALIVE cycle: lives unchanged. hit_pulse still asserts and INVULN is still entered.
- INVULN:
  - Hits ignored.
  - Timer counts 0..INVULN_CYCLES-1, then the FSM returns to ALIVE.
  - Blink counter toggles bm_visible every BLINK_CYCLES clocks, starting with visible=0.
- DEAD:
  - hit and life_up ignored; bm_visible=0; gameover=1.
  - restart loads START_LIVES and enters INVULN (spawn protection).
- restart outside DEAD: ignored.
- invuln = (state==INVULN). bm_visible=1 in ALIVE.
- healthbar_on = (x > BAR_X0) & (x < BAR_X0 + lives*SEG_W) & (y > BAR_Y0) & (y < BAR_Y0+BAR_H). The product is computed at ≥11 bits with no truncation.
- healthbar_rgb = 12'hFF0 when lives==1, else 12'hF00.
- background_rgb = {R,8'h00} with R = (lives*10)/MAX_LIVES (floor, 4 bits). Giving 0 when lives==0.

## Timing
- Reset values: lives=START_LIVES, state=ALIVE, invuln=0, bm_visible=1, hit_pulse=0, gameover=0, timers=0.
- Reset is honoured mid-invulnerability and mid-DEAD with the same values.
- Hit sampled at edge t; lives, state, invuln and hit_pulse update at t+1; hit_pulse deasserts at t+2.
- INVULN entered at t+1 lasts exactly INVULN_CYCLES clocks. A hit on the first ALIVE cycle afterwards is accepted.
- life_up latency: 1 clock. restart latency: 1 clock.
- gameover is a registered state decode, valid the same cycle lives reads 0.
- healthbar_on, healthbar_rgb and background_rgb are combinational from registered lives and x/y, with zero added latency.

## Structure
- Shared package game_pkg:
  - health_state_t enum (ALIVE, INVULN, DEAD)
  - arena wall constants X_WALL_L=48, X_WALL_R=576, Y_WALL_U=32, Y_WALL_D=448
  - colour constants RGB_RED=12'hF00, RGB_YELLOW=12'hFF0, RGB_BLACK=12'h000
- Sub-module invuln_timer:
  - Parametrised down-counter with start/done.
  - Contains the blink divider.
  - Instantiated once.
- FSM, life arithmetic and HUD decode stay in player_health.

## Test plan
- Reset, then a 1-cycle hit via hazard_on[1] -> lives 5→4 next cycle, hit_pulse one cycle, invuln=1 for exactly INVULN_CYCLES (bench overrides to 100), bm_visible toggles every BLINK_CYCLES (10).
- Continuous hit held for 600 cycles with INVULN_CYCLES=100 -> lives decrement at cycles 1, 102, 203, 304, 405. gameover=1 from cycle 405; no further change.
- Simultaneous hit + life_up at lives=3 in ALIVE -> lives stays 3, hit_pulse=1, invuln=1. life_up at lives=5 -> stays 5.
- DEAD, then life_up and hit -> ignored. restart -> lives=5, invuln=1, gameover=0 next cycle. Restart pulse while ALIVE -> no effect.
- HUD sweep:
  - lives=4, y=8: healthbar_on for x=577..591 only.
  - lives=1: healthbar_rgb=FF0, background_rgb=200.
  - lives=5: background_rgb=A00. lives=0: background_rgb=000.
- Reset asserted mid-INVULN at timer=50 -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared arena types, wall limits and colour constants
package game_pkg;

  typedef enum logic [1:0] {
    ALIVE  = 2'd0,
    INVULN = 2'd1,
    DEAD   = 2'd2
  } health_state_t;

  localparam int X_WALL_L = 48;
  localparam int X_WALL_R = 576;
  localparam int Y_WALL_U = 32;
  localparam int Y_WALL_D = 448;

  localparam logic [11:0] RGB_RED    = 12'hF00;
  localparam logic [11:0] RGB_YELLOW = 12'hFF0;
  localparam logic [11:0] RGB_BLACK  = 12'h000;

endpackage

// File: rtl/invuln_timer.sv
// rtl/invuln_timer.sv - invulnerability down-counter with sprite blink divider
module invuln_timer #(
  parameter int INVULN_CYCLES = 150000000,
  parameter int BLINK_CYCLES  = 6250000
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic done,
  output logic blink_on
);

  localparam int CNT_W = $clog2(INVULN_CYCLES + 1);
  localparam int BLK_W = $clog2(BLINK_CYCLES + 1);

  logic [CNT_W-1:0] cnt;
  logic             running;
  logic [BLK_W-1:0] blink_cnt;
  logic             vis;

  // Load the full window on start, then count down; the last count is the done cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      cnt     <= CNT_W'(INVULN_CYCLES - 1);
      running <= 1'b1;
    end else if (running) begin
      if (cnt == '0) begin
        running <= 1'b0;
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  // Sprite starts hidden at window start and flips every BLINK_CYCLES clocks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt <= '0;
      vis       <= 1'b0;
    end else if (start) begin
      blink_cnt <= '0;
      vis       <= 1'b0;
    end else if (running) begin
      if (blink_cnt == BLK_W'(BLINK_CYCLES - 1)) begin
        blink_cnt <= '0;
        vis       <= ~vis;
      end else begin
        blink_cnt <= blink_cnt + BLK_W'(1);
      end
    end
  end

  assign done     = running && (cnt == '0);
  assign blink_on = vis;

endmodule

// File: rtl/player_health.sv
// rtl/player_health.sv - life tracker FSM with invulnerability and health HUD decode
module player_health
  import game_pkg::*;
#(
  parameter int MAX_LIVES     = 5,
  parameter int START_LIVES   = 5,
  parameter int N_HAZARDS     = 2,
  parameter int INVULN_CYCLES = 150000000,
  parameter int BLINK_CYCLES  = 6250000,
  parameter int BAR_X0        = 576,
  parameter int BAR_Y0        = 5,
  parameter int BAR_H         = 8,
  parameter int SEG_W         = 4,
  localparam int LIFE_W       = $clog2(MAX_LIVES + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [9:0]           x,
  input  logic [9:0]           y,
  input  logic                 bm_hb_on,
  input  logic [N_HAZARDS-1:0] hazard_on,
  input  logic                 life_up,
  input  logic                 restart,
  output logic [LIFE_W-1:0]    lives,
  output logic                 invuln,
  output logic                 bm_visible,
  output logic                 hit_pulse,
  output logic                 gameover,
  output logic                 healthbar_on,
  output logic [11:0]          healthbar_rgb,
  output logic [11:0]          background_rgb
);

  localparam logic [LIFE_W-1:0] ONE_LIFE  = LIFE_W'(1);
  localparam logic [LIFE_W-1:0] MAX_L     = LIFE_W'(MAX_LIVES);
  localparam logic [LIFE_W-1:0] START_L   = LIFE_W'(START_LIVES);

  health_state_t     state, state_next;
  logic [LIFE_W-1:0] lives_q, lives_next;
  logic              pulse_q, pulse_next;
  logic              hit;
  logic              timer_start;
  logic              timer_done;
  logic              blink_on;

  assign hit = bm_hb_on & (|hazard_on);

  invuln_timer #(
    .INVULN_CYCLES(INVULN_CYCLES),
    .BLINK_CYCLES (BLINK_CYCLES)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .start   (timer_start),
    .done    (timer_done),
    .blink_on(blink_on)
  );

  // State, life count and hit pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ALIVE;
      lives_q <= START_L;
      pulse_q <= 1'b0;
    end else begin
      state   <= state_next;
      lives_q <= lives_next;
      pulse_q <= pulse_next;
    end
  end

  // Next-state and life arithmetic; a pickup coinciding with a hit cancels the loss.
  always_comb begin
    state_next  = state;
    lives_next  = lives_q;
    pulse_next  = 1'b0;
    timer_start = 1'b0;
    case (state)
      ALIVE: begin
        if (hit) begin
          pulse_next = 1'b1;
          if (!life_up && lives_q == ONE_LIFE) begin
            lives_next = '0;
            state_next = DEAD;
          end else begin
            if (!life_up) begin
              lives_next = lives_q - ONE_LIFE;
            end
            state_next  = INVULN;
            timer_start = 1'b1;
          end
        end else if (life_up && lives_q != MAX_L) begin
          lives_next = lives_q + ONE_LIFE;
        end
      end
      INVULN: begin
        if (life_up && lives_q != MAX_L) begin
          lives_next = lives_q + ONE_LIFE;
        end
        if (timer_done) begin
          state_next = ALIVE;
        end
      end
      DEAD: begin
        if (restart) begin
          lives_next  = START_L;
          state_next  = INVULN;
          timer_start = 1'b1;
        end
      end
      default: begin
        state_next = ALIVE;
      end
    endcase
  end

  assign lives      = lives_q;
  assign invuln     = (state == INVULN);
  assign gameover   = (state == DEAD);
  assign hit_pulse  = pulse_q;
  assign bm_visible = (state == ALIVE) | ((state == INVULN) & blink_on);

  // HUD decode is purely combinational from the registered life count.
  logic [15:0] x_w, y_w, bar_x_end;
  logic [3:0]  bg_r;

  assign x_w       = {6'b0, x};
  assign y_w       = {6'b0, y};
  assign bar_x_end = 16'(BAR_X0) + 16'(lives_q) * 16'(SEG_W);

  assign healthbar_on = (x_w > 16'(BAR_X0)) && (x_w < bar_x_end) &&
                        (y_w > 16'(BAR_Y0)) && (y_w < 16'(BAR_Y0 + BAR_H));

  assign healthbar_rgb  = (lives_q == ONE_LIFE) ? RGB_YELLOW : RGB_RED;

  assign bg_r           = 4'((16'(lives_q) * 16'd10) / 16'(MAX_LIVES));
  assign background_rgb = (lives_q == '0) ? RGB_BLACK : {bg_r, 8'h00};

endmodule

// File: tb/tb_player_health.sv
// tb/tb_player_health.sv - table, directed and randomized checks for player_health
module tb_player_health;

  localparam int MAXL  = 5;
  localparam int START = 5;
  localparam int INV   = 100;
  localparam int BLK   = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  x, y;
  logic        bm_hb_on;
  logic [1:0]  hazard_on;
  logic        life_up, restart;
  logic [2:0]  lives;
  logic        invuln, bm_visible, hit_pulse, gameover, healthbar_on;
  logic [11:0] healthbar_rgb, background_rgb;

  player_health #(
    .MAX_LIVES(MAXL), .START_LIVES(START), .N_HAZARDS(2),
    .INVULN_CYCLES(INV), .BLINK_CYCLES(BLK)
  ) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .bm_hb_on(bm_hb_on),
    .hazard_on(hazard_on), .life_up(life_up), .restart(restart),
    .lives(lives), .invuln(invuln), .bm_visible(bm_visible),
    .hit_pulse(hit_pulse), .gameover(gameover), .healthbar_on(healthbar_on),
    .healthbar_rgb(healthbar_rgb), .background_rgb(background_rgb)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: life count, dead flag, remaining protection and its age.
  int m_lives, m_inv_left, m_age;
  bit m_dead, m_pulse;

  task automatic model_reset();
    m_lives = START; m_dead = 0; m_inv_left = 0; m_age = 0; m_pulse = 0;
  endtask

  task automatic model_step(input bit h, input bit lu, input bit rs);
    m_pulse = 0;
    if (m_dead) begin
      if (rs) begin
        m_lives = START; m_dead = 0; m_inv_left = INV; m_age = 0;
      end
    end else if (m_inv_left > 0) begin
      if (lu && m_lives < MAXL) m_lives++;
      m_inv_left--;
      m_age++;
    end else if (h) begin
      m_pulse = 1;
      if (!lu) m_lives--;
      if (m_lives == 0) m_dead = 1;
      else begin m_inv_left = INV; m_age = 0; end
    end else if (lu && m_lives < MAXL) begin
      m_lives++;
    end
  endtask

  task automatic check_model(input int cyc);
    int e_inv, e_vis, e_hb, e_rgb, e_bg;
    string s;
    e_inv = (!m_dead && m_inv_left > 0) ? 1 : 0;
    e_vis = m_dead ? 0 : (e_inv == 1) ? ((m_age / BLK) % 2) : 1;
    e_hb  = (int'(x) > 576 && int'(x) < 576 + m_lives * 4 && int'(y) > 5 && int'(y) < 13) ? 1 : 0;
    e_rgb = (m_lives == 1) ? 'hFF0 : 'hF00;
    e_bg  = ((m_lives * 10) / MAXL) << 8;
    s = $sformatf("rnd%0d", cyc);
    chk({s, "_lives"}, int'(lives), m_lives);
    chk({s, "_invuln"}, int'(invuln), e_inv);
    chk({s, "_visible"}, int'(bm_visible), e_vis);
    chk({s, "_pulse"}, int'(hit_pulse), int'(m_pulse));
    chk({s, "_gameover"}, int'(gameover), int'(m_dead));
    chk({s, "_hb_on"}, int'(healthbar_on), e_hb);
    chk({s, "_hb_rgb"}, int'(healthbar_rgb), e_rgb);
    chk({s, "_bg_rgb"}, int'(background_rgb), e_bg);
  endtask

  task automatic drive(input bit bm, input bit [1:0] hz, input bit lu, input bit rs,
                       input int xx, input int yy);
    bm_hb_on = bm; hazard_on = hz; life_up = lu; restart = rs;
    x = 10'(xx); y = 10'(yy);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(bm_hb_on && (|hazard_on), life_up, restart);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 2'b00, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic hit_and_wait();
    int g;
    drive(1, 2'b01, 0, 0, 0, 0);
    tick();
    drive(0, 2'b00, 0, 0, 0, 0);
    g = 0;
    while (invuln && g < 300) begin tick(); g++; end
    if (g >= 300) chk("inv_timeout", 1, 0);
  endtask

  task automatic chk_reset_vals(input string p);
    chk({p, "_lives"}, int'(lives), START);
    chk({p, "_invuln"}, int'(invuln), 0);
    chk({p, "_visible"}, int'(bm_visible), 1);
    chk({p, "_pulse"}, int'(hit_pulse), 0);
    chk({p, "_gameover"}, int'(gameover), 0);
  endtask

  typedef struct {
    bit bm; bit [1:0] hz; bit lu; bit rs; int x; int y;
    int e_lives; int e_inv; int e_pulse; int e_go; int e_hb; int e_rgb; int e_bg;
  } vec_t;

  vec_t vecs[10];
  int   chg_q[$];
  int   exp_c[5];
  int   vis_rec[200];
  int   pulse_rec[2];
  int   inv_cnt, prev, go404, go405, g;

  initial begin
    vecs[0] = '{1, 2'b10, 0, 0, 0,   0,  4, 1, 1, 0, 0, 'hF00, 'h800};
    vecs[1] = '{0, 2'b00, 0, 0, 576, 8,  4, 1, 0, 0, 0, 'hF00, 'h800};
    vecs[2] = '{0, 2'b00, 0, 0, 577, 8,  4, 1, 0, 0, 1, 'hF00, 'h800};
    vecs[3] = '{0, 2'b00, 0, 0, 591, 8,  4, 1, 0, 0, 1, 'hF00, 'h800};
    vecs[4] = '{0, 2'b00, 0, 0, 592, 8,  4, 1, 0, 0, 0, 'hF00, 'h800};
    vecs[5] = '{0, 2'b00, 0, 0, 580, 5,  4, 1, 0, 0, 0, 'hF00, 'h800};
    vecs[6] = '{0, 2'b00, 0, 0, 580, 6,  4, 1, 0, 0, 1, 'hF00, 'h800};
    vecs[7] = '{0, 2'b00, 0, 0, 580, 12, 4, 1, 0, 0, 1, 'hF00, 'h800};
    vecs[8] = '{0, 2'b00, 0, 0, 580, 13, 4, 1, 0, 0, 0, 'hF00, 'h800};
    vecs[9] = '{0, 2'b01, 0, 0, 700, 8,  4, 1, 0, 0, 0, 'hF00, 'h800};
    exp_c = '{1, 102, 203, 304, 405};

    // Reset values, then table: one hit via hazard_on[1] and a HUD sweep at lives=4.
    do_reset();
    chk_reset_vals("reset");
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].bm, vecs[i].hz, vecs[i].lu, vecs[i].rs, vecs[i].x, vecs[i].y);
      tick();
      chk($sformatf("vec%0d_lives", i), int'(lives), vecs[i].e_lives);
      chk($sformatf("vec%0d_invuln", i), int'(invuln), vecs[i].e_inv);
      chk($sformatf("vec%0d_pulse", i), int'(hit_pulse), vecs[i].e_pulse);
      chk($sformatf("vec%0d_gameover", i), int'(gameover), vecs[i].e_go);
      chk($sformatf("vec%0d_hb_on", i), int'(healthbar_on), vecs[i].e_hb);
      chk($sformatf("vec%0d_hb_rgb", i), int'(healthbar_rgb), vecs[i].e_rgb);
      chk($sformatf("vec%0d_bg_rgb", i), int'(background_rgb), vecs[i].e_bg);
    end

    // Invulnerability length, pulse width and blink phase after a single hit.
    do_reset();
    drive(1, 2'b10, 0, 0, 0, 0);
    tick();
    drive(0, 2'b00, 0, 0, 0, 0);
    inv_cnt = 0;
    g = 0;
    while (invuln && g < 300) begin
      if (inv_cnt < 200) vis_rec[inv_cnt] = int'(bm_visible);
      if (inv_cnt < 2) pulse_rec[inv_cnt] = int'(hit_pulse);
      inv_cnt++;
      tick();
      g++;
    end
    chk("inv_len", inv_cnt, INV);
    chk("pulse_first", pulse_rec[0], 1);
    chk("pulse_second", pulse_rec[1], 0);
    chk("blink_0", vis_rec[0], 0);
    chk("blink_9", vis_rec[9], 0);
    chk("blink_10", vis_rec[10], 1);
    chk("blink_19", vis_rec[19], 1);
    chk("blink_20", vis_rec[20], 0);
    chk("blink_99", vis_rec[99], 1);
    chk("alive_visible", int'(bm_visible), 1);
    drive(1, 2'b01, 0, 0, 0, 0);
    tick();
    chk("first_alive_hit", int'(lives), 3);

    // Continuous hit held for 600 cycles.
    do_reset();
    drive(1, 2'b11, 0, 0, 0, 0);
    prev = int'(lives);
    go404 = -1; go405 = -1;
    chg_q.delete();
    for (int c = 1; c <= 600; c++) begin
      tick();
      if (int'(lives) != prev) chg_q.push_back(c);
      prev = int'(lives);
      if (c == 404) go404 = int'(gameover);
      if (c == 405) go405 = int'(gameover);
    end
    chk("cont_nchanges", chg_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < chg_q.size()) chk($sformatf("cont_change%0d", i), chg_q[i], exp_c[i]);
    end
    chk("cont_go404", go404, 0);
    chk("cont_go405", go405, 1);
    chk("cont_lives_end", int'(lives), 0);
    chk("cont_go_end", int'(gameover), 1);

    // DEAD ignores pickup and hit; restart respawns protected.
    drive(0, 2'b00, 1, 0, 0, 0);
    tick();
    chk("dead_lifeup", int'(lives), 0);
    drive(1, 2'b01, 0, 0, 0, 0);
    tick();
    chk("dead_hit", int'(lives), 0);
    chk("dead_pulse", int'(hit_pulse), 0);
    chk("dead_visible", int'(bm_visible), 0);
    chk("dead_bg", int'(background_rgb), 'h000);
    drive(0, 2'b00, 0, 1, 0, 0);
    tick();
    chk("restart_lives", int'(lives), 5);
    chk("restart_invuln", int'(invuln), 1);
    chk("restart_gameover", int'(gameover), 0);

    // Restart while ALIVE and pickup at the cap.
    do_reset();
    drive(0, 2'b00, 0, 1, 0, 0);
    tick();
    chk("alive_restart_lives", int'(lives), 5);
    chk("alive_restart_invuln", int'(invuln), 0);
    drive(0, 2'b00, 1, 0, 0, 0);
    tick();
    chk("lifeup_cap", int'(lives), 5);

    // Hit and pickup together at lives=3.
    do_reset();
    hit_and_wait();
    hit_and_wait();
    chk("pre_combo_lives", int'(lives), 3);
    drive(1, 2'b10, 1, 0, 0, 0);
    tick();
    chk("combo_lives", int'(lives), 3);
    chk("combo_pulse", int'(hit_pulse), 1);
    chk("combo_invuln", int'(invuln), 1);
    drive(0, 2'b00, 1, 0, 0, 0);
    tick();
    chk("inv_lifeup", int'(lives), 4);

    // Last life colours.
    do_reset();
    repeat (4) hit_and_wait();
    drive(0, 2'b00, 0, 0, 579, 8);
    #1;
    chk("one_lives", int'(lives), 1);
    chk("one_rgb", int'(healthbar_rgb), 'hFF0);
    chk("one_bg", int'(background_rgb), 'h200);
    chk("one_hb_579", int'(healthbar_on), 1);
    x = 10'd580;
    #1;
    chk("one_hb_580", int'(healthbar_on), 0);

    // Asynchronous reset in the middle of invulnerability.
    do_reset();
    drive(1, 2'b01, 0, 0, 0, 0);
    tick();
    drive(0, 2'b00, 0, 0, 0, 0);
    repeat (50) tick();
    chk("mid_inv_before", int'(invuln), 1);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("async_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    tick();
    chk("post_reset_invuln", int'(invuln), 0);
    chk("post_reset_lives", int'(lives), 5);

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      drive(($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 29) == 0), ($urandom_range(0, 19) == 0),
            int'($urandom_range(570, 600)), int'($urandom_range(0, 20)));
      tick();
      check_model(c);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
